pcie_bar0_regfile_mc: RTL



---
 rtl/pcie_bar0_regfile_mc.sv | 279 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/pcie_bar0_regfile_mc.sv
// pcie_bar0_regfile_mc: BAR0 user register file for PCIe PIO accesses.
// Provides NUM_CH DMA descriptor register sets, a W1C interrupt status/mask
// pair and a directed link-change state machine with a cycle timeout.
// Optional build macro DEBUG_REGS_EN adds a 128-bit debug input that is
// readable at offsets 0x30..0x33; without it those offsets read 0.
//
// Handshake: there is no valid/ready pair on the PIO side. wr_en is a
// single-cycle strobe that is always accepted (wr_busy is tied to 0), and
// rd_data reflects rd_addr one clock later with no request signal.
module pcie_bar0_regfile_mc #(
    parameter int          NUM_CH     = 4,
    parameter int          LC_TIMEOUT = 1048576,
    parameter logic [15:0] VERSION    = 16'h0200
) (
    input  logic                   clk,
    input  logic                   sys_rst_n,
    input  logic [13:0]            rd_addr,
    output logic [31:0]            rd_data,
    input  logic [13:0]            wr_addr,
    input  logic [7:0]             wr_be,
    input  logic [31:0]            wr_data,
    input  logic                   wr_en,
    output logic                   wr_busy,
    output logic [NUM_CH*32-1:0]   ch_addrl,
    output logic [NUM_CH*16-1:0]   ch_addrh,
    output logic [NUM_CH*32-1:0]   ch_length,
    output logic [NUM_CH-1:0]      ch_start,
    input  logic [NUM_CH-1:0]      ch_done,
    output logic                   irq,
    input  logic [15:0]            cfg_command,
    input  logic [15:0]            cfg_lcommand,
    input  logic [4:0]             buttons,
`ifdef DEBUG_REGS_EN
    input  logic [127:0]           debug,
`endif
    input  logic                   user_lnk_up,
    input  logic [5:0]             pl_ltssm_state,
    input  logic                   pl_sel_lnk_rate,
    input  logic [1:0]             pl_sel_lnk_width,
    input  logic                   pl_directed_change_done,
    output logic [1:0]             pl_directed_link_change,
    output logic                   pl_directed_link_speed,
    output logic [1:0]             pl_directed_link_width,
    output logic                   pl_directed_link_auton,
    output logic [1:0]             lc_state
);

    localparam int CW = $clog2(LC_TIMEOUT + 1);

    typedef enum logic [1:0] {
        LC_IDLE    = 2'd0,
        LC_WAIT_L0 = 2'd1,
        LC_DIRECT  = 2'd2
    } lc_state_t;

    // Decode
    logic        rd_hit, wr_hit;
    logic [5:0]  rd_off, wr_off;
    logic [3:0]  rd_ch, wr_ch;
    logic        rd_in_ch, wr_in_ch;
    logic [31:0] be_mask;

    assign rd_hit   = (rd_addr[13:12] == 2'b01);
    assign wr_hit   = wr_en && (wr_addr[13:12] == 2'b01);
    assign rd_off   = rd_addr[5:0];
    assign wr_off   = wr_addr[5:0];
    // Channel window is 0x10..0x2F, four dwords per channel
    assign rd_ch    = rd_off[5:2] - 4'd4;
    assign wr_ch    = wr_off[5:2] - 4'd4;
    assign rd_in_ch = (rd_off[5:4] == 2'b01) || (rd_off[5:4] == 2'b10);
    assign wr_in_ch = (wr_off[5:4] == 2'b01) || (wr_off[5:4] == 2'b10);
    assign be_mask  = {{8{wr_be[3]}}, {8{wr_be[2]}}, {8{wr_be[1]}}, {8{wr_be[0]}}};

    // Upper byte enables and the address bits between the BAR select and
    // the register offset carry no meaning for this block.
    logic unused_bits;
    assign unused_bits = ^{wr_be[7:4], wr_addr[11:6], rd_addr[11:6]};

    // Channel state
    logic [31:0]       addrl_q  [NUM_CH];
    logic [15:0]       addrh_q  [NUM_CH];
    logic [31:0]       length_q [NUM_CH];
    logic [NUM_CH-1:0] ch_busy, ch_dn;
    logic [NUM_CH-1:0] ch_wr, start_req, start_acc;
    logic [NUM_CH-1:0] irq_status, irq_mask, w1c;

    // Link state
    lc_state_t   state;
    logic [CW-1:0] lc_cnt;
    logic        timeout_err, lc_busy;
    logic        req_speed;
    logic [1:0]  req_width;
    logic        go, go_diff;

    // Per-channel write select and start acceptance
    always_comb begin
        ch_wr     = '0;
        start_req = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ch_wr[c]     = wr_hit && wr_in_ch && (wr_ch == 4'(c));
            start_req[c] = ch_wr[c] && (wr_off[1:0] == 2'd3) && wr_be[0] && wr_data[0];
        end
        start_acc = start_req & ~ch_busy;
    end

    // Descriptor registers with byte-lane writes; address/length keep [1:0] at 0
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                addrl_q[c]  <= '0;
                addrh_q[c]  <= 16'h0002;
                length_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_wr[c]) begin
                    case (wr_off[1:0])
                        2'd0: addrl_q[c] <= ((addrl_q[c] & ~be_mask) | (wr_data & be_mask))
                                            & 32'hFFFF_FFFC;
                        2'd1: addrh_q[c] <= (addrh_q[c] & ~be_mask[15:0])
                                            | (wr_data[15:0] & be_mask[15:0]);
                        2'd2: length_q[c] <= ((length_q[c] & ~be_mask) | (wr_data & be_mask))
                                             & 32'hFFFF_FFFC;
                        default: ;
                    endcase
                end
            end
        end
    end

    // Start pulse, busy and done tracking per channel
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ch_start <= '0;
            ch_busy  <= '0;
            ch_dn    <= '0;
        end else begin
            ch_start <= start_acc;
            for (int c = 0; c < NUM_CH; c++) begin
                if (start_acc[c]) begin
                    ch_busy[c] <= 1'b1;
                    ch_dn[c]   <= 1'b0;
                end else if (ch_done[c]) begin
                    ch_busy[c] <= 1'b0;
                    ch_dn[c]   <= 1'b1;
                end
            end
        end
    end

    assign w1c = (wr_hit && (wr_off == 6'h04))
               ? (wr_data[NUM_CH-1:0] & be_mask[NUM_CH-1:0]) : '0;

    // Interrupt status (W1C, completion set wins) and mask (RW)
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            irq_status <= '0;
            irq_mask   <= '0;
        end else begin
            irq_status <= (irq_status & ~w1c) | ch_done;
            if (wr_hit && (wr_off == 6'h05)) begin
                irq_mask <= (irq_mask & ~be_mask[NUM_CH-1:0])
                          | (wr_data[NUM_CH-1:0] & be_mask[NUM_CH-1:0]);
            end
        end
    end

    assign irq = |(irq_status & irq_mask);

    // A go is a LINK write with bit31 set; only acted on while idle
    assign go      = wr_hit && (wr_off == 6'h03) && wr_be[3] && wr_data[31];
    assign go_diff = (wr_data[2] != pl_sel_lnk_rate) || (wr_data[1:0] != pl_sel_lnk_width);
    assign lc_busy = (state != LC_IDLE);
    assign lc_state = state;

    // Directed link change FSM with timeout counter running outside idle
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state                   <= LC_IDLE;
            lc_cnt                  <= '0;
            timeout_err             <= 1'b0;
            req_speed               <= 1'b0;
            req_width               <= 2'b00;
            pl_directed_link_change <= 2'b00;
            pl_directed_link_speed  <= 1'b0;
            pl_directed_link_width  <= 2'b00;
        end else if (state == LC_IDLE) begin
            lc_cnt <= '0;
            if (go) begin
                req_speed <= wr_data[2];
                req_width <= wr_data[1:0];
                if (go_diff) begin
                    timeout_err <= 1'b0;
                    state       <= LC_WAIT_L0;
                end
            end
        end else if (lc_cnt == CW'(LC_TIMEOUT - 1)) begin
            timeout_err             <= 1'b1;
            lc_cnt                  <= '0;
            pl_directed_link_change <= 2'b00;
            pl_directed_link_speed  <= 1'b0;
            pl_directed_link_width  <= 2'b00;
            state                   <= LC_IDLE;
        end else begin
            lc_cnt <= lc_cnt + 1'b1;
            case (state)
                LC_WAIT_L0: begin
                    if (user_lnk_up && (pl_ltssm_state == 6'h16)) begin
                        pl_directed_link_change <= {req_speed != pl_sel_lnk_rate,
                                                    req_width != pl_sel_lnk_width};
                        pl_directed_link_speed  <= req_speed;
                        pl_directed_link_width  <= req_width;
                        state                   <= LC_DIRECT;
                    end
                end
                LC_DIRECT: begin
                    if (pl_directed_change_done || !user_lnk_up) begin
                        pl_directed_link_change <= 2'b00;
                        pl_directed_link_speed  <= 1'b0;
                        pl_directed_link_width  <= 2'b00;
                        state                   <= LC_IDLE;
                    end
                end
                default: state <= LC_IDLE;
            endcase
        end
    end

    // Read mux; channel window and unmapped offsets fall through to 0
    logic [31:0] rd_mux;
    always_comb begin
        rd_mux = '0;
        if (rd_hit) begin
            case (rd_off)
                6'h00: rd_mux = {VERSION, 8'h00, 8'(NUM_CH)};
                6'h01: rd_mux = {27'h0, buttons};
                6'h02: rd_mux = {cfg_command, cfg_lcommand};
                6'h03: rd_mux = {lc_busy, timeout_err, 21'h0, pl_sel_lnk_rate,
                                 pl_sel_lnk_width, pl_ltssm_state};
                6'h04: rd_mux = 32'(irq_status);
                6'h05: rd_mux = 32'(irq_mask);
`ifdef DEBUG_REGS_EN
                6'h30: rd_mux = debug[31:0];
                6'h31: rd_mux = debug[63:32];
                6'h32: rd_mux = debug[95:64];
                6'h33: rd_mux = debug[127:96];
`endif
                default: begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (rd_in_ch && (rd_ch == 4'(c))) begin
                            case (rd_off[1:0])
                                2'd0:    rd_mux = addrl_q[c];
                                2'd1:    rd_mux = {16'h0, addrh_q[c]};
                                2'd2:    rd_mux = length_q[c];
                                default: rd_mux = {30'h0, ch_dn[c], ch_busy[c]};
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    // Registered read data, one cycle after rd_addr
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) rd_data <= '0;
        else            rd_data <= rd_mux;
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_flat
        assign ch_addrl[g*32 +: 32]  = addrl_q[g];
        assign ch_addrh[g*16 +: 16]  = addrh_q[g];
        assign ch_length[g*32 +: 32] = length_q[g];
    end

    assign wr_busy                = 1'b0;
    assign pl_directed_link_auton = 1'b0;

endmodule
